apa102_in: RTL and testbench

- APA102 receiver: oversamples an external APA102 clock/data pair on the system clock and detects the start frame.
- Validates each LED frame header and strips it, then packs the BGR payload MSB-first into 16-bit words.
- Words go out on a write strobe to a memory port, at consecutive addresses from start_address.
- Used to capture LED streams from an upstream controller into the same word-addressed RAM the transmitter reads from, so frames round-trip bit-exact.

---
 rtl/apa102_in_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/apa102_in.sv | 222 ++++++++++++++++++++++
 tb/tb_apa102_in.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_in_pkg.sv
// Shared state encoding and frame geometry for the APA102 receiver.
package apa102_in_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_SYNC,
        S_HEADER,
        S_DATA,
        S_PIXEL_BOUNDARY,
        S_END
    } state_t;

    localparam int START_ZERO_BITS = 32;
    localparam int HEADER_BITS     = 8;
    localparam int PIXEL_BITS      = 24;
    localparam int WORD_BITS       = 16;
    localparam int PACK_BITS       = PIXEL_BITS + WORD_BITS;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous APA102 CI/DI pair into the clk domain and strobes
// once per CI rising edge with the matching DI value.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic clock_in,
    input  logic data_in,
    output logic bit_valid,
    output logic bit_data
);
    logic [1:0] ci_sync;
    logic [1:0] di_sync;
    logic       ci_prev;

    // DI travels through the same depth as CI so the sampled bit stays aligned with its edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ci_sync   <= 2'b00;
            di_sync   <= 2'b00;
            ci_prev   <= 1'b0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
        end else begin
            ci_sync   <= {ci_sync[0], clock_in};
            di_sync   <= {di_sync[0], data_in};
            ci_prev   <= ci_sync[1];
            bit_valid <= ci_sync[1] & ~ci_prev;
            bit_data  <= di_sync[1];
        end
    end

endmodule

// File: rtl/apa102_in.sv
// APA102 receiver: finds the start frame, strips LED headers and packs the BGR
// payload MSB-first into 16-bit words written at consecutive addresses.
module apa102_in
    import apa102_in_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int IDLE_TIMEOUT      = 1024,
    parameter bit END_ON_ONES       = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  start_address,
    input  logic [15:0]                  max_words,
    input  logic                         clock_in,
    input  logic                         data_in,
    output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    output logic [15:0]                  write_data,
    output logic                         write_strobe,
    output logic                         frame_done,
    output logic [15:0]                  frame_word_count,
    output logic [4:0]                   last_brightness,
    output logic                         framing_error,
    output logic                         overflow
);
    localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    state_t                       state, next_state;
    logic                         bit_valid, bit_data;
    logic [5:0]                   zero_cnt;
    logic [4:0]                   bit_cnt;
    logic [HEADER_BITS-1:0]       header_reg;
    logic [PIXEL_BITS-2:0]        pixel_reg;
    logic [PIXEL_BITS-1:0]        pixel_full;
    logic [PACK_BITS-1:0]         pack_buf;
    logic [5:0]                   pack_cnt;
    logic [15:0]                  word_cnt;
    logic [ADDRESS_BUS_WIDTH-1:0] next_addr;
    logic [IDLE_W-1:0]            idle_cnt;

    logic start_frame, header_error, pixel_done, end_ones, append_pixel;
    logic timeout, timeout_error, boundary_zero;
    logic emit_full, emit_flush, emit_word, finish_frame;

    sync_edge_detect u_sync (
        .clk       (clk),
        .rst       (rst),
        .clock_in  (clock_in),
        .data_in   (data_in),
        .bit_valid (bit_valid),
        .bit_data  (bit_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HUNT;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HUNT:   if (start_frame) next_state = S_SYNC;
            S_SYNC: begin
                if (timeout)                    next_state = S_HUNT;
                else if (bit_valid && bit_data) next_state = S_HEADER;
            end
            S_HEADER: begin
                if (timeout)           next_state = S_END;
                else if (header_error) next_state = S_HUNT;
                else if (bit_valid && bit_cnt == 5'(HEADER_BITS - 1)) next_state = S_DATA;
            end
            S_DATA: begin
                if (timeout || end_ones) next_state = S_END;
                else if (pixel_done)     next_state = S_PIXEL_BOUNDARY;
            end
            S_PIXEL_BOUNDARY: begin
                if (timeout)        next_state = S_END;
                else if (bit_valid) next_state = bit_data ? S_HEADER : S_END;
            end
            S_END:    if (finish_frame) next_state = S_HUNT;
            default:  next_state = S_HUNT;
        endcase
    end

    // Per-cycle control decode; full words drain ahead of the END flush.
    always_comb begin
        start_frame   = 1'b0;
        header_error  = 1'b0;
        pixel_done    = 1'b0;
        end_ones      = 1'b0;
        append_pixel  = 1'b0;
        timeout_error = 1'b0;
        boundary_zero = 1'b0;
        emit_flush    = 1'b0;
        finish_frame  = 1'b0;
        pixel_full    = {pixel_reg, bit_data};
        timeout       = (idle_cnt == IDLE_LAST) && !bit_valid &&
                        (state == S_SYNC || state == S_HEADER ||
                         state == S_DATA || state == S_PIXEL_BOUNDARY);
        case (state)
            S_HUNT: start_frame = bit_valid && !bit_data &&
                                  (zero_cnt == 6'(START_ZERO_BITS - 1));
            S_HEADER: begin
                header_error  = bit_valid && !bit_data &&
                                (bit_cnt == 5'd1 || bit_cnt == 5'd2);
                timeout_error = timeout;
            end
            S_DATA: begin
                pixel_done    = bit_valid && (bit_cnt == 5'(PIXEL_BITS - 1));
                end_ones      = pixel_done && END_ON_ONES &&
                                (header_reg == '1) && (pixel_full == '1);
                append_pixel  = pixel_done && !end_ones;
                timeout_error = timeout;
            end
            S_PIXEL_BOUNDARY: boundary_zero = bit_valid && !bit_data;
            S_END: begin
                emit_flush   = (pack_cnt != 6'd0) && (pack_cnt < 6'(WORD_BITS));
                finish_frame = (pack_cnt == 6'd0);
            end
            default: ;
        endcase
        emit_full = (state != S_HUNT) && !append_pixel && (pack_cnt >= 6'(WORD_BITS));
        emit_word = emit_full || emit_flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_cnt         <= '0;
            bit_cnt          <= '0;
            header_reg       <= '0;
            pixel_reg        <= '0;
            pack_buf         <= '0;
            pack_cnt         <= '0;
            word_cnt         <= '0;
            next_addr        <= '0;
            idle_cnt         <= '0;
            write_address    <= '0;
            write_data       <= '0;
            write_strobe     <= 1'b0;
            frame_done       <= 1'b0;
            frame_word_count <= '0;
            last_brightness  <= '0;
            framing_error    <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            frame_done   <= 1'b0;

            if (state == S_HUNT || bit_valid) idle_cnt <= '0;
            else if (idle_cnt != IDLE_LAST)   idle_cnt <= idle_cnt + 1'b1;

            // A zero that closes the pixel stream already counts toward the next start frame.
            if (state == S_HUNT) begin
                if (bit_valid) zero_cnt <= bit_data ? 6'd0 : zero_cnt + 6'd1;
            end else if (boundary_zero) begin
                zero_cnt <= 6'd1;
            end else if (state != S_END) begin
                zero_cnt <= 6'd0;
            end

            if (bit_valid) begin
                case (state)
                    S_SYNC, S_PIXEL_BOUNDARY: if (bit_data) begin
                        header_reg <= 8'h01;
                        bit_cnt    <= 5'd1;
                    end
                    S_HEADER: begin
                        header_reg <= {header_reg[HEADER_BITS-2:0], bit_data};
                        bit_cnt    <= (bit_cnt == 5'(HEADER_BITS - 1)) ? 5'd0 : bit_cnt + 5'd1;
                    end
                    S_DATA: begin
                        pixel_reg <= pixel_full[PIXEL_BITS-2:0];
                        bit_cnt   <= (bit_cnt == 5'(PIXEL_BITS - 1)) ? 5'd0 : bit_cnt + 5'd1;
                    end
                    default: ;
                endcase
            end

            if (start_frame) begin
                framing_error <= 1'b0;
                overflow      <= 1'b0;
                word_cnt      <= '0;
                next_addr     <= ADDRESS_BUS_WIDTH'(start_address);
            end
            if (header_error || timeout_error) framing_error <= 1'b1;
            if (append_pixel) last_brightness <= header_reg[4:0];

            // Packer keeps valid bits left-aligned with zeros below, so a flush is already padded.
            if (start_frame) begin
                pack_buf <= '0;
                pack_cnt <= '0;
            end else if (append_pixel) begin
                pack_buf <= pack_buf | ({pixel_full, {WORD_BITS{1'b0}}} >> pack_cnt);
                pack_cnt <= pack_cnt + 6'(PIXEL_BITS);
            end else if (emit_full) begin
                pack_buf <= pack_buf << WORD_BITS;
                pack_cnt <= pack_cnt - 6'(WORD_BITS);
            end else if (emit_flush) begin
                pack_buf <= '0;
                pack_cnt <= '0;
            end

            if (emit_word) begin
                if (word_cnt < max_words) begin
                    write_strobe  <= 1'b1;
                    write_data    <= pack_buf[PACK_BITS-1 -: WORD_BITS];
                    write_address <= next_addr;
                    next_addr     <= next_addr + 1'b1;
                    if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (finish_frame) begin
                frame_done       <= 1'b1;
                frame_word_count <= word_cnt;
            end
        end
    end

endmodule

// File: tb/tb_apa102_in.sv
// Scoreboard bench for apa102_in: expected writes are queued as LED streams are driven
// and checked by a monitor whenever write_strobe fires.
module tb_apa102_in;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] start_address = 16'h0000;
    logic [15:0] max_words = 16'd64;
    logic        clock_in = 1'b0;
    logic        data_in = 1'b0;
    logic [15:0] write_address;
    logic [15:0] write_data;
    logic        write_strobe;
    logic        frame_done;
    logic [15:0] frame_word_count;
    logic [4:0]  last_brightness;
    logic        framing_error;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    int          writes_seen = 0;
    int          done_seen = 0;
    logic [15:0] done_count = '0;
    logic [4:0]  done_bright = '0;
    logic        done_fe = 1'b0;
    logic        done_ov = 1'b0;

    always #5 clk = ~clk;

    apa102_in dut (
        .clk              (clk),
        .rst              (rst),
        .start_address    (start_address),
        .max_words        (max_words),
        .clock_in         (clock_in),
        .data_in          (data_in),
        .write_address    (write_address),
        .write_data       (write_data),
        .write_strobe     (write_strobe),
        .frame_done       (frame_done),
        .frame_word_count (frame_word_count),
        .last_brightness  (last_brightness),
        .framing_error    (framing_error),
        .overflow         (overflow)
    );

    // Monitor: every strobe is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (write_strobe) begin
            writes_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write got addr=%h data=%h expected no write",
                         write_address, write_data);
            end else begin
                exp_word = exp_q.pop_front();
                if ({write_address, write_data} !== exp_word) begin
                    bad++;
                    $display("[TB] FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             write_address, write_data, exp_word[31:16], exp_word[15:0]);
                end
            end
        end
        if (frame_done) begin
            done_seen++;
            done_count  = frame_word_count;
            done_bright = last_brightness;
            done_fe     = framing_error;
            done_ov     = overflow;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        clock_in = 1'b0;
        data_in  = b;
        repeat (4) @(negedge clk);
        clock_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_run(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic send_pixel(input logic [7:0] hdr, input logic [23:0] pix);
        send_byte(hdr);
        send_byte(pix[23:16]);
        send_byte(pix[15:8]);
        send_byte(pix[7:0]);
    endtask

    task automatic wait_done(input int prev, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_seen != prev) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (done_seen != prev) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({write_strobe, frame_done, framing_error, overflow} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b expected=0000",
                     {write_strobe, frame_done, framing_error, overflow});
        end
        total++;
        if ({write_address, write_data, frame_word_count} !== 48'h0) begin
            bad++;
            $display("[TB] FAIL reset_words got=%h expected=0",
                     {write_address, write_data, frame_word_count});
        end
        total++;
        if (last_brightness !== 5'd0) begin
            bad++;
            $display("[TB] FAIL reset_brightness got=%0d expected=0", last_brightness);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        bit ok;
        start_address = 16'h0100;
        max_words     = 16'd64;
        exp_q.push_back({16'h0100, 16'h1234});
        exp_q.push_back({16'h0101, 16'h5678});
        exp_q.push_back({16'h0102, 16'h9ABC});
        d0 = done_seen;
        send_run(1'b0, 32);
        send_pixel(8'hE5, 24'h123456);
        send_pixel(8'hE5, 24'h789ABC);
        send_run(1'b1, 32);
        wait_done(d0, 200, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL basic_done got=none expected=frame_done"); end
        total++;
        if (done_count !== 16'd3) begin
            bad++; $display("[TB] FAIL basic_count got=%0d expected=3", done_count);
        end
        total++;
        if (done_bright !== 5'd5) begin
            bad++; $display("[TB] FAIL basic_brightness got=%0d expected=5", done_bright);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL basic_missing got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        int d0;
        bit ok;
        exp_q.push_back({16'h0100, 16'hAABB});
        exp_q.push_back({16'h0101, 16'hCC00});
        d0 = done_seen;
        send_run(1'b0, 32);
        send_pixel(8'hE1, 24'hAABBCC);
        wait_done(d0, 1400, ok);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL timeout_done got=none expected=frame_done"); end
        total++;
        if (done_count !== 16'd2) begin
            bad++; $display("[TB] FAIL timeout_count got=%0d expected=2", done_count);
        end
        total++;
        if (done_fe !== 1'b0) begin
            bad++; $display("[TB] FAIL timeout_framing_error got=%b expected=0", done_fe);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL timeout_missing got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_framing_error();
        int d0, w0;
        bit ok;
        d0 = done_seen;
        w0 = writes_seen;
        send_run(1'b0, 32);
        send_byte(8'h60);
        repeat (6) @(negedge clk);
        total++;
        if (framing_error !== 1'b1) begin
            bad++; $display("[TB] FAIL ferr_set got=%b expected=1", framing_error);
        end
        total++;
        if ((writes_seen - w0) !== 0 || done_seen !== d0) begin
            bad++; $display("[TB] FAIL ferr_quiet got writes=%0d dones=%0d expected 0/0",
                            writes_seen - w0, done_seen - d0);
        end
        send_run(1'b0, 32);
        repeat (6) @(negedge clk);
        total++;
        if (framing_error !== 1'b0) begin
            bad++; $display("[TB] FAIL ferr_cleared got=%b expected=0", framing_error);
        end
        exp_q.push_back({16'h0100, 16'h0102});
        exp_q.push_back({16'h0101, 16'h0300});
        d0 = done_seen;
        send_pixel(8'hE3, 24'h010203);
        send_run(1'b1, 32);
        wait_done(d0, 200, ok);
        total++;
        if (!ok || done_count !== 16'd2) begin
            bad++; $display("[TB] FAIL ferr_recover got done=%0b count=%0d expected 1/2", ok, done_count);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL ferr_missing got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_overflow();
        int d0, w0;
        bit ok;
        max_words = 16'd1;
        exp_q.push_back({16'h0100, 16'h1111});
        d0 = done_seen;
        w0 = writes_seen;
        send_run(1'b0, 32);
        send_pixel(8'hE1, 24'h111111);
        send_pixel(8'hE2, 24'h222222);
        send_pixel(8'hE3, 24'h333333);
        send_run(1'b1, 32);
        wait_done(d0, 200, ok);
        total++;
        if (!ok || done_count !== 16'd1) begin
            bad++; $display("[TB] FAIL ovf_count got done=%0b count=%0d expected 1/1", ok, done_count);
        end
        total++;
        if (done_ov !== 1'b1) begin
            bad++; $display("[TB] FAIL ovf_flag got=%b expected=1", done_ov);
        end
        total++;
        if ((writes_seen - w0) !== 1) begin
            bad++; $display("[TB] FAIL ovf_writes got=%0d expected=1", writes_seen - w0);
        end
        total++;
        if (done_bright !== 5'd3) begin
            bad++; $display("[TB] FAIL ovf_brightness got=%0d expected=3", done_bright);
        end
        exp_q.delete();
        max_words = 16'd64;
    endtask

    task automatic test_partial_start();
        int d0, w0;
        bit ok;
        d0 = done_seen;
        w0 = writes_seen;
        send_run(1'b0, 31);
        send_bit(1'b1);
        send_pixel(8'hE1, 24'h445566);
        send_pixel(8'hE2, 24'h778899);
        send_run(1'b1, 32);
        repeat (10) @(negedge clk);
        total++;
        if ((writes_seen - w0) !== 0 || done_seen !== d0) begin
            bad++; $display("[TB] FAIL partial_quiet got writes=%0d dones=%0d expected 0/0",
                            writes_seen - w0, done_seen - d0);
        end
        exp_q.push_back({16'h0100, 16'h4455});
        exp_q.push_back({16'h0101, 16'h6600});
        send_run(1'b0, 32);
        send_pixel(8'hE1, 24'h445566);
        send_run(1'b1, 32);
        wait_done(d0, 200, ok);
        total++;
        if (!ok || done_count !== 16'd2) begin
            bad++; $display("[TB] FAIL partial_frame got done=%0b count=%0d expected 1/2", ok, done_count);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL partial_missing got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok;
        d0 = done_seen;
        send_run(1'b0, 32);
        send_byte(8'hE1);
        send_byte(8'hAA);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({frame_word_count, last_brightness, write_address, write_data} !== 53'h0) begin
            bad++; $display("[TB] FAIL midreset_outputs got count=%0d bright=%0d addr=%h data=%h expected all 0",
                            frame_word_count, last_brightness, write_address, write_data);
        end
        total++;
        if ({write_strobe, frame_done, framing_error, overflow} !== 4'b0000) begin
            bad++; $display("[TB] FAIL midreset_flags got=%b expected=0000",
                            {write_strobe, frame_done, framing_error, overflow});
        end
        clock_in = 1'b0;
        data_in  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (done_seen !== d0) begin
            bad++; $display("[TB] FAIL midreset_no_done got=%0d expected=0", done_seen - d0);
        end
        start_address = 16'h0200;
        exp_q.push_back({16'h0200, 16'hDEAD});
        exp_q.push_back({16'h0201, 16'hBE00});
        send_run(1'b0, 32);
        send_pixel(8'hE4, 24'hDEADBE);
        send_run(1'b1, 32);
        wait_done(d0, 200, ok);
        total++;
        if (!ok || done_count !== 16'd2 || done_bright !== 5'd4) begin
            bad++; $display("[TB] FAIL midreset_frame got done=%0b count=%0d bright=%0d expected 1/2/4",
                            ok, done_count, done_bright);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL midreset_missing got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        $display("[TB] starting apa102_in bench");
        test_reset();
        test_basic();
        test_timeout();
        test_framing_error();
        test_overflow();
        test_partial_start();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
